bp_me_lce_txn_monitor: RTL and testbench

BP_ME_LCE_TXN_MONITOR -- requirements
Module: bp_me_lce_txn_monitor

---
 rtl/bp_me_lce_txn_monitor.sv | 116 +++++++++++
 tb/tb_bp_me_lce_txn_monitor.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bp_me_lce_txn_monitor.sv
// Passive per-channel LCE transaction monitor: tracks request->fill latency,
// completed-transaction counts and sticky protocol errors for each channel.
module bp_me_lce_txn_monitor #(
   parameter int num_lce_p            = 2,
   parameter int paddr_width_p        = 40,
   parameter int block_offset_width_p = 6,
   parameter int lat_width_p          = 16,
   parameter int count_width_p        = 32,
   parameter int timeout_p            = 1024
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,
   input  logic                                   clear_i,
   input  logic [num_lce_p-1:0]                   req_v_i,
   input  logic [num_lce_p-1:0]                   req_ready_i,
   input  logic [num_lce_p*paddr_width_p-1:0]     req_addr_i,
   input  logic [num_lce_p-1:0]                   cmd_v_i,
   input  logic [num_lce_p-1:0]                   cmd_ready_i,
   input  logic [num_lce_p-1:0]                   cmd_done_i,
   input  logic [num_lce_p*paddr_width_p-1:0]     cmd_addr_i,
   output logic [num_lce_p-1:0]                   busy_o,
   output logic [num_lce_p*lat_width_p-1:0]       max_lat_o,
   output logic [num_lce_p*count_width_p-1:0]     txn_count_o,
   output logic [num_lce_p*3-1:0]                 error_o,
   output logic                                   any_error_o
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_TIMEOUT} state_e;

   localparam int TagW = paddr_width_p - block_offset_width_p;
   localparam logic [lat_width_p-1:0] TimeoutLat = lat_width_p'(timeout_p);
   localparam logic [lat_width_p-1:0] LatOne     = lat_width_p'(1);

   for (genvar i = 0; i < num_lce_p; i++) begin : g_ch
      state_e                   state_q;
      logic [TagW-1:0]          tag_q;
      logic [lat_width_p-1:0]   lat_q;
      logic [lat_width_p-1:0]   max_lat_q;
      logic [count_width_p-1:0] cnt_q;
      logic [2:0]               err_q;
      logic                     accept, done_hs, complete;
      logic [TagW-1:0]          req_tag, cmd_tag;
      logic                     unused_offset_bits;

      // Matching is per cache block, so the offset bits never matter.
      assign req_tag  = req_addr_i[i*paddr_width_p+block_offset_width_p +: TagW];
      assign cmd_tag  = cmd_addr_i[i*paddr_width_p+block_offset_width_p +: TagW];
      assign unused_offset_bits = ^{req_addr_i[i*paddr_width_p +: block_offset_width_p],
                                    cmd_addr_i[i*paddr_width_p +: block_offset_width_p]};
      assign accept   = req_v_i[i] & req_ready_i[i];
      assign done_hs  = cmd_v_i[i] & cmd_ready_i[i] & cmd_done_i[i];
      assign complete = done_hs & (cmd_tag == tag_q);

      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i) begin
            state_q   <= S_IDLE;
            tag_q     <= '0;
            lat_q     <= '0;
            max_lat_q <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (done_hs) err_q[2] <= 1'b1;
                  if (accept) begin
                     tag_q   <= req_tag;
                     lat_q   <= LatOne;
                     state_q <= S_BUSY;
                  end
               end
               S_BUSY: begin
                  if (complete) begin
                     if (lat_q > max_lat_q) max_lat_q <= lat_q;
                     if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
                     if (accept) begin
                        tag_q <= req_tag;
                        lat_q <= LatOne;
                     end else begin
                        state_q <= S_IDLE;
                     end
                  end else begin
                     if (done_hs) err_q[2] <= 1'b1;
                     if (accept)  err_q[1] <= 1'b1;
                     // A clear in the timeout cycle drops straight to idle.
                     if (lat_q == TimeoutLat) begin
                        err_q[0] <= 1'b1;
                        state_q  <= clear_i ? S_IDLE : S_TIMEOUT;
                     end else if (lat_q != '1) begin
                        lat_q <= lat_q + 1'b1;
                     end
                  end
               end
               S_TIMEOUT: begin
                  if (complete || clear_i) state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
            // Clear wins over any statistic or error update of this cycle.
            if (clear_i) begin
               max_lat_q <= '0;
               cnt_q     <= '0;
               err_q     <= '0;
            end
         end
      end

      assign busy_o[i]                               = (state_q == S_BUSY);
      assign max_lat_o[i*lat_width_p +: lat_width_p]     = max_lat_q;
      assign txn_count_o[i*count_width_p +: count_width_p] = cnt_q;
      assign error_o[i*3 +: 3]                       = err_q;
   end

   assign any_error_o = |error_o;

endmodule

// File: tb/tb_bp_me_lce_txn_monitor.sv
// Directed bench for bp_me_lce_txn_monitor: four channels, short timeout.
module tb_bp_me_lce_txn_monitor;
   localparam int NL = 4;
   localparam int AW = 40;
   localparam int LW = 16;
   localparam int CW = 32;
   localparam int TO = 8;

   logic              clk = 1'b0;
   logic              reset_r;
   logic              clear_r;
   logic [NL-1:0]     req_v, req_ready, cmd_v, cmd_ready, cmd_done;
   logic [NL*AW-1:0]  req_addr, cmd_addr;
   logic [NL-1:0]     busy;
   logic [NL*LW-1:0]  max_lat;
   logic [NL*CW-1:0]  txn_count;
   logic [NL*3-1:0]   error;
   logic              any_error;

   int total = 0;
   int bad   = 0;
   logic [LW-1:0] exp_q[$];

   bp_me_lce_txn_monitor #(
      .num_lce_p(NL), .paddr_width_p(AW), .block_offset_width_p(6),
      .lat_width_p(LW), .count_width_p(CW), .timeout_p(TO)
   ) dut (
      .clk_i(clk), .reset_i(reset_r), .clear_i(clear_r),
      .req_v_i(req_v), .req_ready_i(req_ready), .req_addr_i(req_addr),
      .cmd_v_i(cmd_v), .cmd_ready_i(cmd_ready), .cmd_done_i(cmd_done),
      .cmd_addr_i(cmd_addr),
      .busy_o(busy), .max_lat_o(max_lat), .txn_count_o(txn_count),
      .error_o(error), .any_error_o(any_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] lat_of(input int ch);
      return max_lat[ch*LW +: LW];
   endfunction
   function automatic logic [CW-1:0] cnt_of(input int ch);
      return txn_count[ch*CW +: CW];
   endfunction
   function automatic logic [2:0] err_of(input int ch);
      return error[ch*3 +: 3];
   endfunction

   task automatic set_req(input int ch, input logic [AW-1:0] a);
      req_v[ch] = 1'b1; req_ready[ch] = 1'b1; req_addr[ch*AW +: AW] = a;
   endtask
   task automatic set_cmd(input int ch, input logic [AW-1:0] a, input logic d);
      cmd_v[ch] = 1'b1; cmd_ready[ch] = 1'b1; cmd_done[ch] = d; cmd_addr[ch*AW +: AW] = a;
   endtask
   // One clock edge with the staged inputs, then return everything to idle.
   task automatic step();
      @(posedge clk); #1;
      req_v = '0; req_ready = '0; cmd_v = '0; cmd_ready = '0; cmd_done = '0; clear_r = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) step();
   endtask

   initial begin
      reset_r = 1'b1; clear_r = 1'b0;
      req_v = '0; req_ready = '0; cmd_v = '0; cmd_ready = '0; cmd_done = '0;
      req_addr = '0; cmd_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_maxlat", 64'(max_lat), 64'h0);
      check("rst_count", 64'(txn_count), 64'h0);
      check("rst_err", 64'(error), 64'h0);
      check("rst_any", 64'(any_error), 64'h0);
      reset_r = 1'b0;
      idle(1);

      // Single transaction on channel 0, latency 5; a non-done cmd in between.
      set_req(0, 40'h1000); step();
      check("c0_busy", 64'(busy[0]), 64'h1);
      idle(1);
      set_cmd(0, 40'h1000, 1'b0); step();
      idle(2);
      set_cmd(0, 40'h1020, 1'b1); step();
      exp_q.push_back(16'd5);
      check("c0_lat", 64'(lat_of(0)), 64'(exp_q.pop_front()));
      check("c0_cnt", 64'(cnt_of(0)), 64'd1);
      check("c0_idle", 64'(busy[0]), 64'h0);
      check("c0_err", 64'(err_of(0)), 64'h0);

      // Back-to-back: latency 3 completes while 0x3000 is accepted.
      set_req(0, 40'h2000); step();
      idle(2);
      set_cmd(0, 40'h2000, 1'b1); set_req(0, 40'h3000); step();
      check("b2b_cnt", 64'(cnt_of(0)), 64'd2);
      check("b2b_busy", 64'(busy[0]), 64'h1);
      check("b2b_lat", 64'(lat_of(0)), 64'd5);
      idle(6);
      set_cmd(0, 40'h3000, 1'b1); step();
      exp_q.push_back(16'd7);
      check("b2b_lat2", 64'(lat_of(0)), 64'(exp_q.pop_front()));
      check("b2b_cnt2", 64'(cnt_of(0)), 64'd3);
      check("b2b_err", 64'(err_of(0)), 64'h0);

      // Timeout on channel 1.
      set_req(1, 40'h4000); step();
      idle(TO - 1);
      check("to_pre_err", 64'(err_of(1)), 64'h0);
      check("to_pre_busy", 64'(busy[1]), 64'h1);
      step();
      check("to_err", 64'(err_of(1)), 64'h1);
      check("to_any", 64'(any_error), 64'h1);
      check("to_busy", 64'(busy[1]), 64'h0);
      set_req(1, 40'h5000); step();
      check("to_acc_ign", 64'(busy[1]), 64'h0);
      check("to_acc_err", 64'(err_of(1)), 64'h1);
      set_cmd(1, 40'h4000, 1'b1); step();
      check("to_late_cnt", 64'(cnt_of(1)), 64'd0);
      check("to_late_lat", 64'(lat_of(1)), 64'd0);
      set_req(1, 40'h6000); step();
      check("to_reacc", 64'(busy[1]), 64'h1);
      set_cmd(1, 40'h6000, 1'b1); step();
      check("to_re_cnt", 64'(cnt_of(1)), 64'd1);
      check("to_re_lat", 64'(lat_of(1)), 64'd1);
      check("to_re_err", 64'(err_of(1)), 64'h1);

      // Overlap and mismatched done on channel 3; original still completes.
      set_req(3, 40'h8000); step();
      set_req(3, 40'h9000); step();
      check("ov_err", 64'(err_of(3)), 64'h2);
      set_cmd(3, 40'h9040, 1'b1); step();
      check("mm_err", 64'(err_of(3)), 64'h6);
      check("mm_busy", 64'(busy[3]), 64'h1);
      set_cmd(3, 40'h8000, 1'b1); step();
      check("ov_lat", 64'(lat_of(3)), 64'd3);
      check("ov_cnt", 64'(cnt_of(3)), 64'd1);
      check("ov_busy", 64'(busy[3]), 64'h0);

      // Staggered channels 2 and 0 with a clear while both are busy.
      set_req(2, 40'hA000); step();
      set_req(0, 40'hB000); step();
      clear_r = 1'b1; step();
      check("clr_lat", 64'(max_lat), 64'h0);
      check("clr_cnt", 64'(txn_count), 64'h0);
      check("clr_err", 64'(error), 64'h0);
      check("clr_any", 64'(any_error), 64'h0);
      check("clr_busy", 64'(busy), 64'h5);
      set_cmd(0, 40'hB000, 1'b1); step();
      set_cmd(2, 40'hA000, 1'b1); step();
      check("st_lat0", 64'(lat_of(0)), 64'd2);
      check("st_cnt0", 64'(cnt_of(0)), 64'd1);
      check("st_lat2", 64'(lat_of(2)), 64'd4);
      check("st_cnt2", 64'(cnt_of(2)), 64'd1);
      check("st_lat13", 64'({lat_of(1), lat_of(3)}), 64'h0);
      check("st_cnt13", 64'({cnt_of(1), cnt_of(3)}), 64'h0);

      // Reset mid-transaction abandons it; a later done is unexpected.
      set_req(1, 40'hC000); step();
      step();
      check("mr_busy", 64'(busy[1]), 64'h1);
      #2 reset_r = 1'b1;
      #1;
      check("mr_rst_busy", 64'(busy), 64'h0);
      check("mr_rst_lat", 64'(max_lat), 64'h0);
      check("mr_rst_cnt", 64'(txn_count), 64'h0);
      @(negedge clk);
      reset_r = 1'b0;
      @(posedge clk); #1;
      set_cmd(1, 40'hC000, 1'b1); step();
      check("mr_unexp", 64'(err_of(1)), 64'h4);
      check("mr_any", 64'(any_error), 64'h1);
      check("mr_cnt", 64'(cnt_of(1)), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
